// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: round-robin arbiter presenting the granted requester as a
// binary index on a valid/ready handshake. After a grant to index k is
// accepted, the next search starts at k+1 (wrapping at N_REQ).
// Optional concurrent checks are compiled in with RR_INDEX_ARBITER_CHECKS_EN.
module rr_index_arbiter #(
    parameter int N_REQ     = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic [IDX_WIDTH-1:0] idx
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LP_LAST = IDX_WIDTH'(N_REQ - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] w_ptr_nxt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [IDX_WIDTH-1:0] w_idx_nxt;
    logic [IDX_WIDTH-1:0] w_idx_inc;
    logic                 w_any_req;
    logic                 w_load;

    // First set bit of v at or after position p, wrapping at N_REQ. Each
    // candidate's circular distance from p is compared instead of rotating
    // the vector, so every index into v is a constant loop position.
    function automatic logic [IDX_WIDTH-1:0] f_sel(
        input logic [N_REQ-1:0]     v,
        input logic [IDX_WIDTH-1:0] p
    );
        logic [IDX_WIDTH-1:0] res;
        int unsigned          best_d;
        int unsigned          d;
        int unsigned          pu;
        res    = '0;
        best_d = N_REQ;
        pu     = int'(p);
        for (int unsigned j = 0; j < N_REQ; j++) begin
            d = (j >= pu) ? (j - pu) : (j + N_REQ - pu);
            if (v[j] && (d < best_d)) begin
                best_d = d;
                res    = IDX_WIDTH'(j);
            end
        end
        return res;
    endfunction

    assign w_any_req = |req;
    assign w_idx_inc = (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;

    // Next-state, next pointer and next index selection
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_idx_nxt   = f_sel(req, r_ptr);
                    w_state_nxt = ST_GRANT;
                    w_load      = 1'b1;
                end
            end
            ST_GRANT: begin
                if (idx_ready) begin
                    w_ptr_nxt = w_idx_inc;
                    if (w_any_req) begin
                        w_idx_nxt = f_sel(req, w_idx_inc);
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer and index registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign idx_valid = (r_state == ST_GRANT);
    assign idx       = r_idx;

`ifdef RR_INDEX_ARBITER_CHECKS_EN
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        idx_valid |-> (int'(idx) < N_REQ));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (idx_valid && !idx_ready) |=> (idx_valid && $stable(idx)));

    a_load_requested: assert property (@(posedge clk) disable iff (rst)
        w_load |-> req[w_idx_nxt]);

    a_no_empty_load: assert property (@(posedge clk) disable iff (rst)
        (req == '0) |-> !w_load);
`endif

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: an 8-requester instance and a 5-requester
// instance, each with an expected-index queue drained by a handshake monitor.
module tb_rr_index_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] idx;
    logic [4:0] req5;
    logic       rdy5;
    logic       valid5;
    logic [2:0] idx5;

    int          checks;
    int          failures;
    int unsigned exp_q[$];
    int unsigned exp5_q[$];

    rr_index_arbiter #(.N_REQ(8), .IDX_WIDTH(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .idx_valid (valid),
        .idx_ready (rdy),
        .idx       (idx)
    );

    rr_index_arbiter #(.N_REQ(5), .IDX_WIDTH(3)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .req       (req5),
        .idx_valid (valid5),
        .idx_ready (rdy5),
        .idx       (idx5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8-requester instance: compare on each handshake
    always @(negedge clk) begin
        if (!rst && valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb8_unexpected actual=%0d required=none", idx);
            end else begin
                chk("sb8_idx", 32'(idx), exp_q.pop_front());
            end
        end
    end

    // Monitor for the 5-requester instance
    always @(negedge clk) begin
        if (!rst && valid5 && rdy5) begin
            if (exp5_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb5_unexpected actual=%0d required=none", idx5);
            end else begin
                chk("sb5_idx", 32'(idx5), exp5_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        req  = 8'hFF;
        rdy  = 1'b1;
        req5 = '0;
        rdy5 = 1'b0;

        // Reset held with all requests: no grant
        repeat (3) cyc();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst5_valid", 32'(valid5), 0);

        // Full rotation with constant requests and constant ready
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
        exp_q.push_back(1);
        rst = 1'b0;
        cyc();
        chk("rot_first_valid", 32'(valid), 1);
        chk("rot_first_idx", 32'(idx), 0);
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk("rot_valid", 32'(valid), 1);
        end
        req = 8'h00;
        cyc();
        chk("rot_end_valid", 32'(valid), 0);

        // Single request with backpressure; grant held after req drops
        req = 8'b0000_0100;
        rdy = 1'b0;
        exp_q.push_back(2);
        cyc();
        chk("bp_valid", 32'(valid), 1);
        chk("bp_idx", 32'(idx), 2);
        req = 8'h00;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_hold_valid", 32'(valid), 1);
            chk("bp_hold_idx", 32'(idx), 2);
        end
        rdy = 1'b1;
        cyc();
        chk("bp_release_valid", 32'(valid), 0);

        // Sparse wrap: 6, then 7 and 0 across the wrap, then sole requester 0
        req = 8'b0100_0000;
        exp_q.push_back(6);
        cyc();
        chk("sw_first_idx", 32'(idx), 6);
        req = 8'b1000_0001;
        exp_q.push_back(7);
        cyc();
        req = 8'b0000_0001;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(0);
            cyc();
        end
        req = 8'h00;
        cyc();
        chk("sw_end_valid", 32'(valid), 0);

        // Reset in the middle of a stalled grant
        req = 8'b0010_0000;
        rdy = 1'b0;
        cyc();
        chk("mg_valid", 32'(valid), 1);
        chk("mg_idx", 32'(idx), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mg_async_valid", 32'(valid), 0);
        chk("mg_async_idx", 32'(idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 8'b0010_0001;
        rdy = 1'b1;
        exp_q.push_back(0);
        cyc();
        chk("mg_first_idx", 32'(idx), 0);
        exp_q.push_back(5);
        cyc();
        chk("mg_second_idx", 32'(idx), 5);
        req = 8'h00;
        cyc();
        chk("mg_end_valid", 32'(valid), 0);

        // Non-power-of-two requester count wraps at 5
        for (int k = 0; k < 5; k++) exp5_q.push_back(k);
        exp5_q.push_back(0);
        req5 = 5'b11111;
        rdy5 = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("n5_valid", 32'(valid5), 1);
            chk("n5_range", 32'(idx5 < 3'd5), 1);
            cyc();
        end
        chk("n5_last_range", 32'(idx5 < 3'd5), 1);
        req5 = '0;
        cyc();
        chk("n5_end_valid", 32'(valid5), 0);

        // Everything issued must have been observed
        repeat (2) cyc();
        chk("sb8_drain", exp_q.size(), 0);
        chk("sb5_drain", exp5_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the binary-to-one-hot decoder.
- Selects one of N_REQ requesters and presents its binary index on a valid/ready handshake.
- The consumer (decoder plus its select logic) reads idx and regenerates the one-hot grant.
- Fairness: after a grant to index k is accepted, the search for the next grant starts at k+1.

Parameters:
- N_REQ, 8, number of requesters; legal range 2..2**IDX_WIDTH.
- IDX_WIDTH, 3, width of the binary index output; must satisfy N_REQ <= 2**IDX_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  N_REQ  request vector; bit i high = requester i wants a grant.
- idx_valid  output  1  idx holds a valid grant.
- idx_ready  input  1  consumer accepts idx this cycle.
- idx  output  IDX_WIDTH  binary index of the granted requester.

Behaviour:
- Reset (async assert, sync release): idx_valid=0, idx=0, state=IDLE, ptr=0. Outputs go to reset values without waiting for a clock edge.
- Registers: ptr (IDX_WIDTH bits) is the search start; idx and idx_valid are registered outputs. No combinational path from req or idx_ready to any output.
- Search function sel(v, p): first set bit of v scanning p, p+1, ..., N_REQ-1, 0, ..., p-1. Index arithmetic wraps at N_REQ, not at 2**IDX_WIDTH (N_REQ-1 + 1 -> 0).
- State IDLE (idx_valid=0):
  - If |req at an edge: idx<=sel(req,ptr), idx_valid<=1, go to GRANT. Latency is 1 cycle from req sampled to idx_valid high.
  - If req==0: stay in IDLE; idx holds its last value.
- State GRANT (idx_valid=1):
  - If idx_ready=0: idx and idx_valid hold stable. Requester idx dropping its req does not withdraw the grant; no retraction.
  - If idx_ready=1 (handshake): ptr<=wrap(idx+1).
    - If |req: idx<=sel(req, wrap(idx+1)) and stay in GRANT. This gives back-to-back grants at 1 per cycle.
    - Otherwise: idx_valid<=0 and go to IDLE.
  - The next-grant search uses the same-cycle req, including the requester just served. It wins again only if it is the sole requester.
- Simultaneous events:
  - A req bit rising in the handshake cycle is eligible immediately.
  - rst overrides everything.
- idx_ready while idx_valid=0 is ignored.
- Reset mid-operation: pending grant is discarded, ptr returns to 0. The first grant after reset is sel(req,0).
- N_REQ not a power of 2: idx never exceeds N_REQ-1. Bits of req are only N_REQ wide, so there are no phantom requesters.

Optional Feature:
- Macro RR_INDEX_ARBITER_CHECKS_EN.
- When defined, the following concurrent checks are compiled in:
  - idx < N_REQ whenever idx_valid=1.
  - idx and idx_valid stable across an edge when idx_valid=1 and idx_ready=0 (rst low).
  - req[idx] was high in the cycle the grant was loaded.
  - No grant is loaded when req==0.
  - Assertions are disabled while rst=1.
- When undefined: no check logic or simulation constructs are present; functional behaviour is identical.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> idx_valid=0 and idx=0 before the next clk edge; req=8'hFF held during reset -> no grant until rst released, then idx=0 one edge later.
- Single request and backpressure: req=8'b0000_0100 in IDLE at edge t -> idx_valid=1, idx=2 after t. Hold idx_ready=0 for 3 cycles with req dropped to 0 -> idx stays 2, valid stays 1. Then idx_ready=1 for one cycle -> idx_valid=0 next cycle.
- Full rotation: req=8'hFF constant, idx_ready=1 constant -> idx sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles with idx_valid continuously 1.
- Sparse wrap: after grant 6 accepted, req=8'b1000_0001 -> next idx=7. On accept, next idx=0. With only req[0] high afterwards -> idx=0 repeatedly on each accept.
- Non-power-of-2 config (N_REQ=5, IDX_WIDTH=3): req=5'b11111, idx_ready=1 -> 0,1,2,3,4,0. idx never 5..7. With checks macro defined, no assertion fires.
- Reset mid-grant: idx_valid=1, idx=5, idx_ready=0, pulse rst between edges -> idx_valid=0 immediately. Release with req=8'b0010_0001 -> first grant idx=0 (ptr reset), then idx=5 on accept.
